// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage buffer.
// Optional perf counters are enabled with PIPE_STAGE_BUF_PERF_EN.
package pipe_pkg;

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      PB_EMPTY = 2'd0,
      PB_FULL  = 2'd1,
      PB_SKID  = 2'd2
   } pipe_buf_state_e;

   localparam int PERF_CNT_W  = 32;
   localparam int FLUSH_CNT_W = 16;

endpackage

// File: rtl/pipe_buf_perf_cnt.sv
// Stall, bubble and flush event counters for pipe_stage_buf.
// Counters wrap on overflow; present only under PIPE_STAGE_BUF_PERF_EN.
module pipe_buf_perf_cnt
   import pipe_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   out_valid,
   input  logic                   out_ready,
   input  logic                   flush,
   input  logic [1:0]             occupancy,
   output logic [PERF_CNT_W-1:0]  stall_cnt,
   output logic [PERF_CNT_W-1:0]  bubble_cnt,
   output logic [FLUSH_CNT_W-1:0] flush_cnt
);

   logic stall_ev, bubble_ev, flush_ev;

   assign stall_ev  = out_valid & ~out_ready;
   assign bubble_ev = ~out_valid & out_ready;
   // A flush of an already empty stage discards nothing, so it is not counted.
   assign flush_ev  = flush & (occupancy != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (stall_ev)  stall_cnt  <= stall_cnt + 1'b1;
         if (bubble_ev) bubble_cnt <= bubble_cnt + 1'b1;
         if (flush_ev)  flush_cnt  <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and registered in_ready.
// Define PIPE_STAGE_BUF_PERF_EN to add stall/bubble/flush counter outputs.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   input  logic                   flush,
   output logic [1:0]             occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0]  stall_cnt,
   output logic [PERF_CNT_W-1:0]  bubble_cnt,
   output logic [FLUSH_CNT_W-1:0] flush_cnt
`endif
);

   pipe_buf_state_e  state_q, state_d;
   logic             in_ready_q, out_valid_q;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             accept, issue;
   logic             load_main, main_from_skid, load_skid;

   // Flush suppresses the accept; an issue in the same cycle still completes.
   assign accept = in_valid & in_ready_q & ~flush;
   assign issue  = out_valid_q & out_ready;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = PB_EMPTY;
      end else begin
         case (state_q)
            PB_EMPTY: begin
               if (accept) begin
                  state_d   = PB_FULL;
                  load_main = 1'b1;
               end
            end
            PB_FULL: begin
               if (accept && issue) begin
                  load_main = 1'b1;
               end else if (issue) begin
                  state_d = PB_EMPTY;
               end else if (accept) begin
                  state_d   = PB_SKID;
                  load_skid = 1'b1;
               end
            end
            PB_SKID: begin
               if (issue) begin
                  state_d        = PB_FULL;
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = PB_EMPTY;
         endcase
      end
   end

   // Handshake flags come straight from flops so no ready path crosses the stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PB_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != PB_SKID);
         out_valid_q <= (state_d != PB_EMPTY);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= RESET_VAL;
         skid_q <= RESET_VAL;
      end else begin
         if (load_main) main_q <= main_from_skid ? skid_q : in_data;
         if (load_skid) skid_q <= in_data;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = state_q;

   always_ff @(posedge clk) begin
      if (!rst) assert (occupancy != 2'd3) else $error("pipe_stage_buf: illegal occupancy 3");
   end

`ifdef PIPE_STAGE_BUF_PERF_EN
   pipe_buf_perf_cnt u_perf (
      .clk        (clk),
      .rst        (rst),
      .out_valid  (out_valid_q),
      .out_ready  (out_ready),
      .flush      (flush),
      .occupancy  (occupancy),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
      .flush_cnt  (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed plus random bench for pipe_stage_buf against a queue-based reference model.
// Perf-counter checks are compiled in when PIPE_STAGE_BUF_PERF_EN is defined.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int          W  = 32;
   localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, flush;
   logic [W-1:0] in_data, out_data;
   logic [1:0]   occupancy;
`ifdef PIPE_STAGE_BUF_PERF_EN
   logic [PERF_CNT_W-1:0]  stall_cnt, bubble_cnt;
   logic [FLUSH_CNT_W-1:0] flush_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Reference: ordered list of held beats, capacity 2.
   logic [W-1:0] mq[$];
   logic [PERF_CNT_W-1:0]  m_stall, m_bubble;
   logic [FLUSH_CNT_W-1:0] m_flush;

   pipe_stage_buf #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_BUF_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
      .flush_cnt  (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".out_valid"}, W'(out_valid), W'(mq.size() != 0));
      chk({tag, ".in_ready"},  W'(in_ready),  W'(mq.size() < 2));
      chk({tag, ".occupancy"}, W'(occupancy), W'(mq.size()));
      if (mq.size() != 0) chk({tag, ".out_data"}, out_data, mq[0]);
   endtask

   task automatic model_reset();
      mq.delete();
      m_stall = '0; m_bubble = '0; m_flush = '0;
   endtask

   // One clock: drive, check current state, advance the model, cross the edge.
   task automatic cyc(input string tag, input logic iv, input logic [W-1:0] d,
                      input logic ordy, input logic fl);
      bit acc, iss;
      in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
      #1;
      chk_outputs(tag);
      iss = (mq.size() != 0) && ordy;
      acc = iv && (mq.size() < 2) && !fl;
      if (mq.size() != 0 && !ordy) m_stall++;
      if (mq.size() == 0 && ordy)  m_bubble++;
      if (fl && mq.size() != 0)    m_flush++;
      if (fl) mq.delete();
      else begin
         if (iss) void'(mq.pop_front());
         if (acc) mq.push_back(d);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      model_reset();
      #2;
      chk("reset.out_valid", W'(out_valid), '0);
      chk("reset.in_ready",  W'(in_ready), W'(1));
      chk("reset.occupancy", W'(occupancy), '0);
      chk("reset.out_data",  out_data, RV);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      // Streaming at full throughput
      for (int i = 1; i <= 8; i++) cyc("stream", 1'b1, W'(i), 1'b1, 1'b0);
      cyc("stream_drain", 1'b0, '0, 1'b1, 1'b0);
      cyc("stream_empty", 1'b0, '0, 1'b1, 1'b0);

      // Backpressure fills the skid entry, then drains in order
      cyc("bp_a", 1'b1, 32'hA, 1'b0, 1'b0);
      cyc("bp_b", 1'b1, 32'hB, 1'b0, 1'b0);
      cyc("bp_hold0", 1'b1, 32'hF, 1'b0, 1'b0);
      cyc("bp_hold1", 1'b0, '0, 1'b0, 1'b0);
      cyc("bp_issue_a", 1'b0, '0, 1'b1, 1'b0);
      cyc("bp_issue_b", 1'b0, '0, 1'b1, 1'b0);
      cyc("bp_empty", 1'b0, '0, 1'b1, 1'b0);

      // Flush while in SKID discards both entries and the offered beat
      cyc("fl_a", 1'b1, 32'hA, 1'b0, 1'b0);
      cyc("fl_b", 1'b1, 32'hB, 1'b0, 1'b0);
      cyc("fl_skid", 1'b1, 32'hC, 1'b0, 1'b1);
      cyc("fl_after", 1'b0, '0, 1'b1, 1'b0);
      cyc("fl_after2", 1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset while in SKID
      cyc("ar_a", 1'b1, 32'h11, 1'b0, 1'b0);
      cyc("ar_b", 1'b1, 32'h22, 1'b0, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst.out_valid", W'(out_valid), '0);
      chk("arst.in_ready",  W'(in_ready), W'(1));
      chk("arst.occupancy", W'(occupancy), '0);
      chk("arst.out_data",  out_data, RV);
      model_reset();
      #2 rst = 1'b0;
      @(posedge clk); #1;
      cyc("arst_idle", 1'b0, '0, 1'b0, 1'b0);

      // Simultaneous accept and issue in FULL
      cyc("ai_5", 1'b1, 32'h5, 1'b1, 1'b0);
      cyc("ai_6", 1'b1, 32'h6, 1'b1, 1'b0);
      cyc("ai_hold", 1'b0, '0, 1'b0, 1'b0);
      cyc("ai_drain", 1'b0, '0, 1'b1, 1'b0);

      // Random traffic with occasional flush
      for (int i = 0; i < 400; i++)
         cyc("rand", 1'($urandom_range(0, 3) != 0), $urandom(),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

`ifdef PIPE_STAGE_BUF_PERF_EN
      // Three clean stall cycles on top of whatever the run accumulated
      cyc("pf_fill", 1'b1, 32'h77, 1'b1, 1'b1);
      cyc("pf_load", 1'b1, 32'h78, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc("pf_stall", 1'b0, '0, 1'b0, 1'b0);
      chk("perf.stall_cnt",  stall_cnt,  m_stall);
      chk("perf.bubble_cnt", bubble_cnt, m_bubble);
      chk("perf.flush_cnt",  W'(flush_cnt), W'(m_flush));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised, elastic pipeline-stage register replacing the fixed load-enable stage registers between IF/ID/EX/MEM/WB.
- Carries one opaque payload of WIDTH bits with a valid/ready handshake, synchronous flush, and a 2-entry skid buffer so that in_ready is a registered signal.
- Lets stalls propagate backward one stage per cycle without combinational ready chains.
- Sits between any two pipeline stages; the payload is packed by the instantiating stage.

Parameters:
- WIDTH, 32, payload width in bits (1..1024).
- RESET_VAL, '0, payload register contents after reset; WIDTH bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents payload.
- in_ready  out  1  stage can accept; registered.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds valid payload for downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload to downstream; registered.
- flush  in  1  synchronous kill of all held entries (branch mispredict/trap).
- occupancy  out  2  number of valid entries, 0..2.

Behaviour:
- Reset (async, rst=1): state EMPTY, out_valid=0, in_ready=1, occupancy=0, main and skid data regs = RESET_VAL.
- Accept: in_valid & in_ready at an edge. Issue: out_valid & out_ready at an edge.
- Storage: main reg drives out_data/out_valid; skid reg captures in_data only when an accept occurs while main is full and not issuing.
- States:
  - EMPTY (occ 0): accept -> FULL; main <= in_data.
  - FULL (occ 1):
    - accept & issue -> FULL; main <= in_data.
    - issue only -> EMPTY.
    - accept only -> SKID; skid <= in_data.
  - SKID (occ 2): in_ready=0, so no accept. Issue -> FULL; main <= skid.
- in_ready = (state != SKID), driven from a state flop.
- Latency: 1 cycle in_data -> out_data when not backpressured. Full throughput of 1 beat/cycle with out_ready held high.
- Payload stability: while out_valid=1 and out_ready=0, out_data and out_valid hold. Upstream must likewise hold in_data while in_valid & ~in_ready.
- flush=1: next state EMPTY regardless of in_valid/out_ready; no accept that cycle; data regs unchanged (don't-care). An issue in the flush cycle still completes, since downstream sampled it.
- Flush vs reset: rst dominates flush.
- Reset mid-transfer: entries lost; no beat emitted.
- out_ready while out_valid=0: ignored.
- occupancy equals state encoding EMPTY=0, FULL=1, SKID=2. Value 3 is illegal: assertion error.

Optional Feature:
Macro PIPE_STAGE_BUF_PERF_EN.
- Defined: adds outputs stall_cnt (32), bubble_cnt (32), flush_cnt (16). All reset to 0, wrap on overflow, no saturation.
  - stall_cnt increments each cycle out_valid & ~out_ready.
  - bubble_cnt increments each cycle ~out_valid & out_ready.
  - flush_cnt increments each cycle flush=1 with occupancy != 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package pipe_pkg: enum pipe_buf_state_e {PB_EMPTY, PB_FULL, PB_SKID} (2-bit); localparam PERF_CNT_W=32, FLUSH_CNT_W=16.
- Existing rv32i_control_word and stage payload structs stay in rv32i_types; stages pack/unpack them into in_data/out_data.
- One sub-module, pipe_buf_perf_cnt, holding the three counters, instantiated only under the macro.

Test Plan:
- Streaming: WIDTH=32, out_ready=1, in_valid=1, in_data=1,2,3,... for 8 cycles -> out_data 1..8 one cycle later; in_ready stays 1; occupancy stays 1.
- Backpressure:
  - Send 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0 after the second accept, out_data=0xA stable.
  - Raise out_ready -> 0xA then 0xB issue in order; in_ready returns to 1 the cycle after 0xA issues.
- Flush in SKID: hold 0xA/0xB, assert flush for one cycle with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy=0, 0xC not accepted; 0xA and 0xB never observed downstream.
- Async reset mid-SKID: assert rst between edges -> out_valid=0, in_ready=1, out_data=RESET_VAL immediately, without waiting for a clock edge.
- Simultaneous accept and issue in FULL: main=0x5, in_data=0x6, both handshakes -> next out_data=0x6, occupancy 1, skid unused.
- PIPE_STAGE_BUF_PERF_EN:
  - 3 cycles of out_valid=1/out_ready=0 -> stall_cnt=3.
  - Preload stall_cnt=0xFFFFFFFF, one more stall cycle -> stall_cnt wraps to 0.
